// File: rtl/regfile_pkg.sv
// Shared register-file constants and address type used by the register file
// and its writeback arbiter.
package regfile_pkg;
  localparam int REG_ADDR_W   = $clog2(32);
  localparam int SCALAR_WIDTH = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = reg_addr_t'(0);
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner,
// and the pointer moves only when a grant is issued.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          hold,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW:0]   cand_s;
  logic [IW-1:0] idx_s;
  logic          found_s;
  logic          sel_s;

  // Scan requesters from ptr+1 upward (mod N); a reset cycle behaves as a hold.
  always_comb begin
    cand_s  = '0;
    idx_s   = '0;
    found_s = 1'b0;
    sel_s   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand_s  = {1'b0, ptr_q} + (IW+1)'(i);
      cand_s  = (cand_s >= (IW+1)'(N)) ? (cand_s - (IW+1)'(N)) : cand_s;
      sel_s   = !found_s && req[cand_s[IW-1:0]] && !hold && !rst;
      idx_s   = sel_s ? cand_s[IW-1:0] : idx_s;
      found_s = found_s | sel_s;
    end
    grant     = found_s ? (N'(1) << idx_s) : '0;
    grant_idx = idx_s;
    ptr_d     = found_s ? idx_s : ptr_q;
  end

  // Pointer register; reset leaves source 0 as the first choice.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IW'(N-1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback port arbiter plus busy scoreboard for the scalar register file.
// Optional bypass outputs are enabled with REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter  int REGISTERS = 32,
  parameter  int WIDTH     = SCALAR_WIDTH,
  parameter  int NUM_SRC   = 3,
  localparam int AW        = $clog2(REGISTERS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       src_valid,
  output logic [NUM_SRC-1:0]       src_ready,
  input  logic [NUM_SRC*AW-1:0]    src_addr,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     wb_hold,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_addr,
  output logic [WIDTH-1:0]         rf_wdata,
`ifdef REGFILE_WB_BYPASS_EN
  output logic                     byp_hit1,
  output logic                     byp_hit2,
  output logic [WIDTH-1:0]         byp_data,
`endif
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_rd,
  input  logic [AW-1:0]            chk_a1,
  input  logic [AW-1:0]            chk_a2,
  input  logic [AW-1:0]            chk_rd,
  output logic                     hazard
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]   grant_s;
  logic [IW-1:0]        gidx_s;
  logic                 hs_s;
  logic [AW-1:0]        sel_addr_s;
  logic [WIDTH-1:0]     sel_data_s;
  logic                 sel_nz_s;

  logic                 rf_we_q,    rf_we_d;
  logic [AW-1:0]        rf_addr_q,  rf_addr_d;
  logic [WIDTH-1:0]     rf_wdata_q, rf_wdata_d;
  logic [REGISTERS-1:0] busy_q,     busy_d;
  logic [REGISTERS-1:0] clr_s,      set_s;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (src_valid),
    .hold      (wb_hold),
    .grant     (grant_s),
    .grant_idx (gidx_s)
  );

  assign src_ready = grant_s;

  // Select the winner's payload and form next-state for port and scoreboard.
  always_comb begin
    hs_s       = |grant_s;
    sel_addr_s = src_addr[gidx_s*AW +: AW];
    sel_data_s = src_data[gidx_s*WIDTH +: WIDTH];
    sel_nz_s   = (sel_addr_s != AW'(ZERO_REG));

    rf_we_d    = hs_s & sel_nz_s;
    rf_addr_d  = (hs_s & sel_nz_s) ? sel_addr_s : rf_addr_q;
    rf_wdata_d = (hs_s & sel_nz_s) ? sel_data_s : rf_wdata_q;

    clr_s  = (hs_s & sel_nz_s) ? (REGISTERS'(1) << sel_addr_s) : '0;
    set_s  = (issue_valid && (issue_rd != AW'(ZERO_REG))) ? (REGISTERS'(1) << issue_rd) : '0;
    // Set is applied after clear so a same-edge reissue keeps the register busy.
    busy_d = ((busy_q & ~clr_s) | set_s) & {{(REGISTERS-1){1'b1}}, 1'b0};
  end

  // Write-port and scoreboard registers; reset drops any in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_addr  = rf_addr_q;
  assign rf_wdata = rf_wdata_q;

  // Busy is already cleared by the time a write sits on the port, so a busy
  // bit seen alongside a matching write means it was re-set and must stall.
  assign hazard = busy_q[chk_a1] | busy_q[chk_a2] | busy_q[chk_rd];

`ifdef REGFILE_WB_BYPASS_EN
  assign byp_hit1 = rf_we_q & (rf_addr_q == chk_a1) & (chk_a1 != AW'(ZERO_REG));
  assign byp_hit2 = rf_we_q & (rf_addr_q == chk_a2) & (chk_a2 != AW'(ZERO_REG));
  assign byp_data = rf_wdata_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write latency,
// scoreboard set/clear races, zero register, hold and mid-stream reset.
module tb_regfile_wb_arbiter;

  localparam int NS = 3;
  localparam int AW = 5;
  localparam int W  = 16;

  logic             clk;
  logic             rst;
  logic [NS-1:0]    src_valid;
  logic [NS-1:0]    src_ready;
  logic [NS*AW-1:0] src_addr;
  logic [NS*W-1:0]  src_data;
  logic             wb_hold;
  logic             rf_we;
  logic [AW-1:0]    rf_addr;
  logic [W-1:0]     rf_wdata;
  logic             issue_valid;
  logic [AW-1:0]    issue_rd;
  logic [AW-1:0]    chk_a1;
  logic [AW-1:0]    chk_a2;
  logic [AW-1:0]    chk_rd;
  logic             hazard;
`ifdef REGFILE_WB_BYPASS_EN
  logic             byp_hit1;
  logic             byp_hit2;
  logic [W-1:0]     byp_data;
`endif

  int errors = 0;
  int checks = 0;
  int seq [6] = '{2, 0, 1, 2, 0, 1};

  regfile_wb_arbiter #(.REGISTERS(32), .WIDTH(W), .NUM_SRC(NS)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_addr    (src_addr),
    .src_data    (src_data),
    .wb_hold     (wb_hold),
    .rf_we       (rf_we),
    .rf_addr     (rf_addr),
    .rf_wdata    (rf_wdata),
`ifdef REGFILE_WB_BYPASS_EN
    .byp_hit1    (byp_hit1),
    .byp_hit2    (byp_hit2),
    .byp_data    (byp_data),
`endif
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .chk_a1      (chk_a1),
    .chk_a2      (chk_a2),
    .chk_rd      (chk_rd),
    .hazard      (hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input logic [W-1:0] d);
    src_valid[i]         = v;
    src_addr[i*AW +: AW] = a;
    src_data[i*W +: W]   = d;
  endtask

  initial begin
    rst = 1'b1; src_valid = '0; src_addr = '0; src_data = '0; wb_hold = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; chk_a1 = '0; chk_a2 = '0; chk_rd = '0;
    tick(); tick();
    src_valid = 3'b111; #1;
    chk("ready_in_reset", 32'(src_ready), 32'd0);
    src_valid = 3'b000;
    chk("reset_we", 32'(rf_we), 32'd0);
    chk("reset_addr", 32'(rf_addr), 32'd0);
    chk("reset_wdata", 32'(rf_wdata), 32'd0);
    chk("reset_hazard", 32'(hazard), 32'd0);
    rst = 1'b0;

    // Reserve r5, then source 1 alone writes it.
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0; chk_a1 = 5'd5; #1;
    chk("hazard_r5_busy", 32'(hazard), 32'd1);
    set_src(1, 1'b1, 5'd5, 16'h1234); #1;
    chk("single_ready", 32'(src_ready), 32'b010);
    tick();
    chk("single_we", 32'(rf_we), 32'd1);
    chk("single_addr", 32'(rf_addr), 32'd5);
    chk("single_wdata", 32'(rf_wdata), 32'h1234);
    set_src(1, 1'b0, 5'd0, 16'h0000); #1;
    chk("hazard_r5_clear", 32'(hazard), 32'd0);
    chk_a1 = 5'd0;

    // All three request continuously; pointer now sits at 1.
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 5'(i + 1), 16'hA000 + 16'(i));
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr_ready_%0d", k), 32'(src_ready), 32'd1 << seq[k]);
      tick();
      chk($sformatf("rr_we_%0d", k), 32'(rf_we), 32'd1);
      chk($sformatf("rr_addr_%0d", k), 32'(rf_addr), 32'(seq[k] + 1));
      chk($sformatf("rr_wdata_%0d", k), 32'(rf_wdata), 32'hA000 + 32'(seq[k]));
    end
    src_valid = 3'b000;

    // RAW hazard on r7 lasts until its writeback handshakes.
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0; chk_a1 = 5'd7; #1;
    chk("hazard_r7_a", 32'(hazard), 32'd1);
    tick();
    chk("hazard_r7_b", 32'(hazard), 32'd1);
    set_src(0, 1'b1, 5'd7, 16'h0777); #1;
    chk("r7_ready", 32'(src_ready), 32'b001);
    chk("hazard_r7_c", 32'(hazard), 32'd1);
    tick();
    src_valid = 3'b000; #1;
    chk("hazard_r7_done", 32'(hazard), 32'd0);
    chk("r7_we", 32'(rf_we), 32'd1);
    chk("r7_addr", 32'(rf_addr), 32'd7);
    chk_a1 = 5'd0;

    // Same-edge reissue and writeback of r9: set wins.
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    set_src(2, 1'b1, 5'd9, 16'h0999); chk_a2 = 5'd9; #1;
    chk("r9_ready", 32'(src_ready), 32'b100);
    tick();
    issue_valid = 1'b0; src_valid = 3'b000; #1;
    chk("hazard_r9_reissue", 32'(hazard), 32'd1);
    chk("r9_we", 32'(rf_we), 32'd1);
    chk("r9_addr", 32'(rf_addr), 32'd9);
    set_src(1, 1'b1, 5'd9, 16'h0000); #1;
    chk("r9b_ready", 32'(src_ready), 32'b010);
    tick();
    src_valid = 3'b000; #1;
    chk("hazard_r9_clear", 32'(hazard), 32'd0);
    chk_a2 = 5'd0;

    // Register 0: handshake happens, no write, no reservation.
    set_src(0, 1'b1, 5'd0, 16'hFFFF); issue_valid = 1'b1; issue_rd = 5'd0; #1;
    chk("r0_ready", 32'(src_ready), 32'b001);
    chk("r0_hazard_pre", 32'(hazard), 32'd0);
    tick();
    src_valid = 3'b000; issue_valid = 1'b0; #1;
    chk("r0_we", 32'(rf_we), 32'd0);
    chk("r0_hazard", 32'(hazard), 32'd0);

    // The zero-register grant still advanced the pointer to 0.
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 5'(i + 1), 16'hB000 + 16'(i));
    #1;
    chk("after_r0_ready", 32'(src_ready), 32'b010);
    wb_hold = 1'b1; #1;
    chk("hold_ready", 32'(src_ready), 32'd0);
    tick();
    chk("hold_we", 32'(rf_we), 32'd0);
    chk("hold_ready_b", 32'(src_ready), 32'd0);
    wb_hold = 1'b0; #1;
    chk("unhold_ready", 32'(src_ready), 32'b010);

    // Reset while a write is on the port and r12 is reserved.
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    chk("pend_we", 32'(rf_we), 32'd1);
    chk("pend_addr", 32'(rf_addr), 32'd2);
    rst = 1'b1; issue_valid = 1'b0; chk_a1 = 5'd12; #1;
    chk("pend_hazard_r12", 32'(hazard), 32'd1);
    chk("rst_ready", 32'(src_ready), 32'd0);
    tick();
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_addr", 32'(rf_addr), 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    rst = 1'b0; #1;
    chk("post_rst_ready", 32'(src_ready), 32'b001);
    src_valid = 3'b000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
